if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address fetched first after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, instruction placed in the IF/ID register on bubble or flush.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PCWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
REQ-006 IFID_Write  input  1  1 = IF/ID register may load; 0 = hold IF/ID contents.
REQ-007 branch_taken  input  1  redirect request from the execute stage.
REQ-008 branch_target  input  64  redirect address, valid with branch_taken.
REQ-009 instr_in  input  32  instruction memory read data for pc_out, available in the same cycle.
REQ-010 pc_out  output  64  current fetch address to instruction memory.
REQ-011 IFID_pc  output  64  PC of the instruction held in IF/ID.
REQ-012 IFID_instr  output  32  instruction held in IF/ID.
REQ-013 IFID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-014 IFID_rs1, IFID_rs2  output  5 each  IFID_instr[19:15] and IFID_instr[24:20], fed to hazard detection.
REQ-015 fetch_state  output  2  FSM state: BOOT=0, RUN=1, STALL=2, FLUSH=3.
REQ-016 stall_count, flush_count  output  32 each  performance counters (see Configuration).

Function
REQ-017 Per-cycle priority SHALL be: reset > branch_taken > stall > normal advance.
REQ-018 Normal advance (PCWrite=1, IFID_Write=1, no branch): pc <= pc+4; IF/ID <= {pc_out, instr_in}; IFID_valid <= 1.
REQ-019 PC arithmetic SHALL be unsigned modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-020 branch_taken=1: pc <= {branch_target[63:2], 2'b00}; IF/ID <= {pc_out, NOP_INSTR}; IFID_valid <= 0, regardless of PCWrite and IFID_Write.
REQ-021 PCWrite=0 without branch: pc holds its value.
REQ-022 IFID_Write=0 without branch: IFID_pc, IFID_instr and IFID_valid hold their values.
REQ-023 IFID_Write=1 with PCWrite=0: IF/ID loads {pc_out, instr_in}, valid 1; the same instruction re-enters on the next advance.
REQ-024 PCWrite=1 with IFID_Write=0: the PC advances and the instruction at the old PC is dropped; the combination is legal and not checked.
REQ-025 FSM next state: reset -> BOOT; branch_taken -> FLUSH; else PCWrite=0 or IFID_Write=0 -> STALL; else -> RUN.
REQ-026 BOOT SHALL last exactly one cycle after reset deasserts, with IFID_valid=0 throughout.
REQ-027 FLUSH SHALL be a one-cycle state that then follows REQ-025.
REQ-028 State encoding SHALL match REQ-015.
REQ-029 Back-to-back branch_taken in consecutive cycles: each redirect applies and the last target wins.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set: pc <= RESET_PC; IFID_pc <= 0; IFID_instr <= NOP_INSTR; IFID_valid <= 0; fetch_state <= BOOT; both counters <= 0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override all other inputs in that cycle.
REQ-032 No output SHALL be X after the first reset edge.

Configuration
REQ-033 Macro IF_ID_PERF_COUNTERS_EN, when defined, SHALL enable the counters:
  - stall_count increments in each non-reset, non-branch cycle with PCWrite=0 or IFID_Write=0.
  - flush_count increments in each non-reset cycle with branch_taken=1.
  - Both saturate at 32'hFFFF_FFFF.
REQ-034 When IF_ID_PERF_COUNTERS_EN is undefined, stall_count and flush_count SHALL be constant 0 and no counter flops are synthesized.

Verification
REQ-035 Reset release, RESET_PC=0, PCWrite=IFID_Write=1, instr_in=0x00500093 -> first cycle: pc_out=0, IFID_valid=0, fetch_state=BOOT; next edge: IFID_pc=0, IFID_instr=0x00500093, IFID_valid=1, pc_out=4.
REQ-036 Load-use stall: at pc_out=0x10, PCWrite=IFID_Write=0 for 1 cycle -> pc_out stays 0x10; IF/ID unchanged; fetch_state=STALL; stall_count +1 (macro defined).
REQ-037 branch_taken=1, branch_target=0x203, PCWrite=0 same cycle -> pc_out=0x200; IFID_instr=0x00000013, IFID_valid=0; fetch_state=FLUSH; flush_count +1.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC, normal advance -> pc_out=0.
REQ-039 Reset asserted during a stall with pc=0x40 -> next edge: pc_out=RESET_PC, IFID_valid=0, counters 0, fetch_state=BOOT.
REQ-040 Build without IF_ID_PERF_COUNTERS_EN, repeat REQ-036 and REQ-037 -> stall_count=flush_count=0 throughout.

Source files
------------

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Instruction-fetch stage plus the IF/ID pipeline register.
//   Holds the fetch PC. Each cycle it either advances, holds for a hazard
//   stall, or redirects for a taken branch. The fetched instruction is
//   latched into IF/ID together with its PC.
//
// Configuration macro:
//   IF_ID_PERF_COUNTERS_EN - when defined, stall/flush performance counters
//                            are built. Otherwise both outputs are tied to 0.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   PCWrite        in   1 = PC may advance, 0 = hold PC
//   IFID_Write     in   1 = IF/ID may load, 0 = hold IF/ID
//   branch_taken   in   redirect request from execute
//   branch_target  in   [63:0] redirect address (low 2 bits ignored)
//   instr_in       in   [31:0] imem read data for pc_out (same cycle)
//   pc_out         out  [63:0] current fetch address
//   IFID_pc        out  [63:0] PC of the instruction held in IF/ID
//   IFID_instr     out  [31:0] instruction held in IF/ID
//   IFID_valid     out  1 = real instruction, 0 = bubble
//   IFID_rs1/rs2   out  [4:0] source register fields of IFID_instr
//   fetch_state    out  [1:0] BOOT=0, RUN=1, STALL=2, FLUSH=3
//   stall_count    out  [31:0] saturating stall-cycle counter
//   flush_count    out  [31:0] saturating branch-flush counter
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [63:0] pc_out,
  output logic [63:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic [4:0]  IFID_rs1,
  output logic [4:0]  IFID_rs2,
  output logic [1:0]  fetch_state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] pc_q;
  logic        stall_cycle;

  // A branch outranks any stall request, so a stall only counts when no
  // redirect is happening in the same cycle.
  assign stall_cycle = !branch_taken && (!PCWrite || !IFID_Write);

  // Program counter. Addition wraps naturally modulo 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (branch_taken) begin
      pc_q <= {branch_target[63:2], 2'b00};
    end else if (PCWrite) begin
      pc_q <= pc_q + 64'd4;
    end
  end

  // IF/ID register. A branch squashes whatever was fetched this cycle,
  // regardless of the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      IFID_pc    <= 64'h0;
      IFID_instr <= NOP_INSTR;
      IFID_valid <= 1'b0;
    end else if (branch_taken) begin
      IFID_pc    <= pc_q;
      IFID_instr <= NOP_INSTR;
      IFID_valid <= 1'b0;
    end else if (IFID_Write) begin
      IFID_pc    <= pc_q;
      IFID_instr <= instr_in;
      IFID_valid <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. The state only reports what the datapath did in the
  // last cycle; BOOT does not suppress the first fetch.
  always_comb begin
    state_d = RUN;
    if (branch_taken) begin
      state_d = FLUSH;
    end else if (stall_cycle) begin
      state_d = STALL;
    end
  end

`ifdef IF_ID_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_taken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 32'h0;
  assign flush_count = 32'h0;
`endif

  assign pc_out      = pc_q;
  assign fetch_state = state_q;
  assign IFID_rs1    = IFID_instr[19:15];
  assign IFID_rs2    = IFID_instr[24:20];

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  // Scoreboard entry: {pc, ifid_pc, ifid_instr, valid, state, stall, flush}
  localparam int W = 64 + 64 + 32 + 1 + 2 + 32 + 32;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b1;
  logic        IFID_Write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic [31:0] instr_in = 32'h0;
  logic [63:0] pc_out;
  logic [63:0] IFID_pc;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic [1:0]  fetch_state;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  always #5 clk = ~clk;

  if_id_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_in(instr_in), .pc_out(pc_out), .IFID_pc(IFID_pc),
    .IFID_instr(IFID_instr), .IFID_valid(IFID_valid), .IFID_rs1(IFID_rs1),
    .IFID_rs2(IFID_rs2), .fetch_state(fetch_state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int num_checks = 0;
  int num_errors = 0;

  // reference model state
  logic [63:0] m_pc = RESET_PC;
  logic [63:0] m_ifid_pc = 64'h0;
  logic [31:0] m_instr = NOP_INSTR;
  logic        m_valid = 1'b0;
  logic [1:0]  m_state = 2'd0;
  logic [31:0] m_stall = 32'h0;
  logic [31:0] m_flush = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the reference model by one edge with the current inputs.
  task automatic model_step(input logic rst, input logic pcw, input logic ifw,
                            input logic br, input logic [63:0] tgt,
                            input logic [31:0] ins);
    if (rst) begin
      m_pc = RESET_PC; m_ifid_pc = 64'h0; m_instr = NOP_INSTR;
      m_valid = 1'b0; m_state = 2'd0; m_stall = 32'h0; m_flush = 32'h0;
    end else if (br) begin
      m_ifid_pc = m_pc; m_instr = NOP_INSTR; m_valid = 1'b0;
      m_pc = {tgt[63:2], 2'b00};
      m_state = 2'd3;
`ifdef IF_ID_PERF_COUNTERS_EN
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
`endif
    end else begin
      if (ifw) begin
        m_ifid_pc = m_pc; m_instr = ins; m_valid = 1'b1;
      end
      if (pcw) m_pc = m_pc + 64'd4;
      if (!pcw || !ifw) begin
        m_state = 2'd2;
`ifdef IF_ID_PERF_COUNTERS_EN
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
      end else begin
        m_state = 2'd1;
      end
    end
  endtask

  // ---------------- driver task ----------------
  task automatic step(input logic rst, input logic pcw, input logic ifw,
                      input logic br, input logic [63:0] tgt,
                      input logic [31:0] ins);
    logic [W-1:0] e;
    @(negedge clk);
    reset = rst; PCWrite = pcw; IFID_Write = ifw;
    branch_taken = br; branch_target = tgt; instr_in = ins;
    model_step(rst, pcw, ifw, br, tgt, ins);
    exp_q.push_back({m_pc, m_ifid_pc, m_instr, m_valid, m_state, m_stall, m_flush});
    @(posedge clk);
    #1;
    check("sb_not_empty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_out",      pc_out,      e[W-1 -: 64]);
      check("IFID_pc",     IFID_pc,     e[W-65 -: 64]);
      check("IFID_instr",  64'(IFID_instr), 64'(e[W-129 -: 32]));
      check("IFID_valid",  64'(IFID_valid), 64'(e[W-161]));
      check("fetch_state", 64'(fetch_state), 64'(e[W-162 -: 2]));
      check("stall_count", 64'(stall_count), 64'(e[63:32]));
      check("flush_count", 64'(flush_count), 64'(e[31:0]));
      check("IFID_rs1",    64'(IFID_rs1), 64'(e[W-129-12 -: 5]));
      check("IFID_rs2",    64'(IFID_rs2), 64'(e[W-129-7 -: 5]));
    end
  endtask

  task automatic adv(input logic [31:0] ins);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, ins);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_stall_one;
  logic [31:0] exp_flush_one;
  logic [31:0] held_instr;
  logic [63:0] held_pc;
  logic [31:0] base_stall;
  logic [31:0] base_flush;

  initial begin
`ifdef IF_ID_PERF_COUNTERS_EN
    exp_stall_one = 32'd1;
    exp_flush_one = 32'd1;
`else
    exp_stall_one = 32'd0;
    exp_flush_one = 32'd0;
`endif

    // Reset and boot cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 32'h00500093);
    check("boot_pc", pc_out, 64'h0);
    check("boot_valid", 64'(IFID_valid), 64'd0);
    check("boot_state", 64'(fetch_state), 64'd0);
    check("boot_instr", 64'(IFID_instr), 64'(NOP_INSTR));
    check("boot_counts", 64'({stall_count, flush_count}), 64'd0);

    // First fetch after reset.
    adv(32'h00500093);
    check("first_ifid_pc", IFID_pc, 64'h0);
    check("first_ifid_instr", 64'(IFID_instr), 64'h00500093);
    check("first_valid", 64'(IFID_valid), 64'd1);
    check("first_pc", pc_out, 64'h4);
    check("first_state", 64'(fetch_state), 64'd1);

    adv(32'h00A00113);
    adv(32'h002081B3);
    adv(32'h0031A023);
    check("pc_at_10", pc_out, 64'h10);

    // Load-use stall at 0x10.
    held_instr = IFID_instr;
    held_pc = IFID_pc;
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0001A283);
    check("stall_pc", pc_out, 64'h10);
    check("stall_ifid_instr", 64'(IFID_instr), 64'(held_instr));
    check("stall_ifid_pc", IFID_pc, held_pc);
    check("stall_state", 64'(fetch_state), 64'd2);
    check("stall_count_1", 64'(stall_count), 64'(exp_stall_one));
    adv(32'h0001A283);

    // Branch with PCWrite low in the same cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'h203, 32'h12345678);
    check("br_pc", pc_out, 64'h200);
    check("br_instr", 64'(IFID_instr), 64'h00000013);
    check("br_valid", 64'(IFID_valid), 64'd0);
    check("br_state", 64'(fetch_state), 64'd3);
    check("flush_count_1", 64'(flush_count), 64'(exp_flush_one));

    // Back-to-back branches: last target wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h300, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h405, 32'h22222222);
    check("b2b_pc", pc_out, 64'h404);
    adv(32'h00000033);
    check("after_flush_state", 64'(fetch_state), 64'd1);

    // PCWrite=0, IFID_Write=1: same instruction loaded, PC holds.
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h00C58533);
    check("pcw0_pc", pc_out, 64'h408);
    check("pcw0_ifid_pc", IFID_pc, 64'h408);
    adv(32'h00C58533);
    check("pcw0_refetch_pc", IFID_pc, 64'h408);
    // PCWrite=1, IFID_Write=0: PC advances, instruction dropped.
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 32'h00D60633);
    check("ifw0_pc", pc_out, 64'h410);
    check("ifw0_ifid_pc", IFID_pc, 64'h408);

    // PC wrap-around.
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
    adv(32'h00100073);
    check("wrap_pc", pc_out, 64'h0);
    check("wrap_ifid_pc", IFID_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           {$urandom, $urandom}, $urandom);
    end

    // Counters track a burst of stalls and flushes.
    base_stall = stall_count;
    base_flush = flush_count;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 64'h80, 32'h0);
`ifdef IF_ID_PERF_COUNTERS_EN
    check("stall_burst", 64'(stall_count - base_stall), 64'd5);
    check("flush_burst", 64'(flush_count - base_flush), 64'd3);
`else
    check("stall_tied0", 64'(stall_count), 64'd0);
    check("flush_tied0", 64'(flush_count), 64'd0);
`endif

    // Reset during a stall at pc 0x40.
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h40, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    check("pre_reset_pc", pc_out, 64'h40);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    check("rst_stall_pc", pc_out, RESET_PC);
    check("rst_stall_valid", 64'(IFID_valid), 64'd0);
    check("rst_stall_state", 64'(fetch_state), 64'd0);
    check("rst_stall_counts", 64'({stall_count, flush_count}), 64'd0);

    // Reset during a branch request.
    adv(32'h00500093);
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'h900, 32'h0);
    check("rst_br_pc", pc_out, RESET_PC);
    check("rst_br_state", 64'(fetch_state), 64'd0);
    check("rst_br_flush", 64'(flush_count), 64'd0);
    adv(32'h00500093);
    check("boot_len_state", 64'(fetch_state), 64'd1);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #200000;
    num_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $fatal(1, "watchdog");
  end

endmodule
